tempsense_multi_ctrl: RTL

- Parametrised next-generation controller for the temperature-dependent delay cell (`tempsense`).
- Drives N_CHAN cells, one at a time, round-robin. Each channel can be converted by a full linear DAC sweep or by successive approximation (SAR).
- Averages 2^N_AVG_LOG2 conversions per channel, then holds each channel's sum in a result register. A one-cycle valid strobe announces each update.
- Sits between the chip IO wrapper and the `tempsense` instances. The analog cells stay outside this block.

---
 rtl/tempsense_multi_ctrl.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tempsense_multi_ctrl.sv
// Multi-channel controller for the tempsense delay cell. Converts each channel
// in turn, either by a full linear DAC sweep or by successive approximation,
// and accumulates 2^N_AVG_LOG2 conversions into a per-channel result register.

// Per-channel slice: output drive muxing plus the result/saturation registers.
module tempsense_multi_chan #(
  parameter int N_VDAC = 6,
  parameter int RW     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic [N_VDAC-1:0] ph_dac,
  input  logic              ph_en,
  input  logic              ph_pre_n,
  input  logic              wr,
  input  logic [RW-1:0]     wr_data,
  input  logic              wr_sat,
  output logic [N_VDAC-1:0] dac_data,
  output logic              dac_en,
  output logic              precharge_n,
  output logic [RW-1:0]     result,
  output logic              sat
);

  // Unselected cells are parked: DAC all-ones, disabled, held in precharge.
  assign dac_data    = sel ? ph_dac   : '1;
  assign dac_en      = sel ? ph_en    : 1'b0;
  assign precharge_n = sel ? ph_pre_n : 1'b0;

  // Result only changes when this channel finishes its averaging run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      sat    <= 1'b0;
    end else if (wr && sel) begin
      result <= wr_data;
      sat    <= wr_sat;
    end
  end

endmodule

module tempsense_multi_ctrl #(
  parameter int N_VDAC     = 6,
  parameter int N_CHAN     = 2,
  parameter int N_AVG_LOG2 = 2,
  parameter int N_IDLE     = 14,
  localparam int CW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int RW = N_VDAC + N_AVG_LOG2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_enable,
  input  logic                     i_mode,
  input  logic [CW-1:0]            i_chan_sel,
  input  logic [N_CHAN-1:0]        i_tempdelay,
  output logic [N_CHAN*N_VDAC-1:0] o_dac_data,
  output logic [N_CHAN-1:0]        o_dac_en,
  output logic [N_CHAN-1:0]        o_precharge_n,
  output logic [RW-1:0]            o_result,
  output logic                     o_valid,
  output logic [CW-1:0]            o_chan,
  output logic                     o_busy,
  output logic [N_CHAN-1:0]        o_sat
);

  localparam int AW       = (N_AVG_LOG2 > 0) ? N_AVG_LOG2 : 1;
  localparam int AVG_LAST = (1 << N_AVG_LOG2) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_TRANS, S_MEAS, S_EVAL, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [N_IDLE-1:0]   idle_cnt;
  logic                mode;
  logic [CW-1:0]       ch;
  logic [AW-1:0]       avg_idx;
  logic [RW-1:0]       acc;
  logic                sticky;
  logic [N_VDAC-1:0]   sweep_code;
  logic [N_VDAC-1:0]   bit_mask;
  logic [N_VDAC-1:0]   res;
  logic                found;

  logic                start;
  logic                run;
  logic                sample;
  logic [N_VDAC-1:0]   trial;
  logic                conv_last, avg_last, ch_last;
  logic [N_VDAC-1:0]   conv_res;
  logic                conv_sat;
  logic [RW-1:0]       acc_nxt;
  logic                sticky_nxt;
  logic                wr;
  logic [N_VDAC-1:0]   ph_dac;
  logic                ph_en, ph_pre_n;
  logic [N_CHAN-1:0]   sel;

  logic [N_CHAN-1:0][N_VDAC-1:0] dac_arr;
  logic [N_CHAN-1:0][RW-1:0]     res_arr;

  assign start     = (state == S_IDLE) && (idle_cnt == '0) && i_enable;
  assign run       = (state == S_PRE) || (state == S_TRANS) ||
                     (state == S_MEAS) || (state == S_EVAL);
  assign sample    = i_tempdelay[ch];
  // SAR tries the current result with the bit under test set.
  assign trial     = mode ? (res | bit_mask) : sweep_code;
  assign conv_last = mode ? bit_mask[0] : (sweep_code == '0);
  assign avg_last  = (avg_idx == AW'(AVG_LAST));
  assign ch_last   = (ch == CW'(N_CHAN - 1));
  assign wr        = (state == S_EVAL) && conv_last && avg_last;
  assign o_busy    = (state != S_IDLE);

  // Final conversion value and saturation, folding in the sample being taken now.
  always_comb begin
    conv_res = '0;
    conv_sat = 1'b0;
    if (mode) begin
      conv_res = sample ? trial : res;
      conv_sat = (conv_res == '1) || ((conv_res == '0) && !sample);
    end else begin
      conv_res = found ? res : '0;
      conv_sat = found ? (res == '1) : !sample;
    end
    acc_nxt    = acc + RW'(conv_res);
    sticky_nxt = sticky | conv_sat;
  end

  // Next state and the shared drive pattern for the active channel.
  always_comb begin
    state_nxt = state;
    ph_dac    = '1;
    ph_en     = 1'b0;
    ph_pre_n  = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PRE;
      S_PRE: begin
        ph_en     = 1'b1;
        state_nxt = S_TRANS;
      end
      S_TRANS: begin
        ph_dac    = '0;
        ph_en     = 1'b1;
        ph_pre_n  = ~clk;  // release precharge on the low half of the cycle
        state_nxt = S_MEAS;
      end
      S_MEAS: begin
        ph_dac    = trial;
        ph_en     = 1'b1;
        ph_pre_n  = 1'b1;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        ph_dac    = trial;
        ph_en     = 1'b1;
        ph_pre_n  = 1'b1;
        state_nxt = (conv_last && avg_last && ch_last) ? S_DONE : S_PRE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Conversion, averaging and channel sequencing datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt   <= '0;
      mode       <= 1'b0;
      ch         <= '0;
      avg_idx    <= '0;
      acc        <= '0;
      sticky     <= 1'b0;
      sweep_code <= '1;
      bit_mask   <= '0;
      res        <= '0;
      found      <= 1'b0;
      o_valid    <= 1'b0;
      o_chan     <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (idle_cnt != '0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end else if (i_enable) begin
            mode       <= i_mode;
            ch         <= '0;
            avg_idx    <= '0;
            acc        <= '0;
            sticky     <= 1'b0;
            sweep_code <= '1;
            bit_mask   <= {1'b1, {(N_VDAC-1){1'b0}}};
            res        <= '0;
            found      <= 1'b0;
          end
        end
        S_EVAL: begin
          if (!conv_last) begin
            if (mode) begin
              if (sample) res <= trial;
              bit_mask <= bit_mask >> 1;
            end else begin
              if (sample && !found) begin
                res   <= sweep_code;
                found <= 1'b1;
              end
              sweep_code <= sweep_code - 1'b1;
            end
          end else begin
            // Arm the next conversion whatever comes after this one.
            sweep_code <= '1;
            bit_mask   <= {1'b1, {(N_VDAC-1){1'b0}}};
            res        <= '0;
            found      <= 1'b0;
            if (!avg_last) begin
              avg_idx <= avg_idx + 1'b1;
              acc     <= acc_nxt;
              sticky  <= sticky_nxt;
            end else begin
              o_valid <= 1'b1;
              o_chan  <= ch;
              acc     <= '0;
              sticky  <= 1'b0;
              avg_idx <= '0;
              ch      <= ch_last ? '0 : ch + 1'b1;
            end
          end
        end
        S_DONE: idle_cnt <= N_IDLE'(1);
        default: ;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_CHAN; k++) begin : g_chan
      assign sel[k] = run && (ch == CW'(k));
      tempsense_multi_chan #(.N_VDAC(N_VDAC), .RW(RW)) u_chan (
        .clk         (clk),
        .reset_n     (reset_n),
        .sel         (sel[k]),
        .ph_dac      (ph_dac),
        .ph_en       (ph_en),
        .ph_pre_n    (ph_pre_n),
        .wr          (wr),
        .wr_data     (acc_nxt),
        .wr_sat      (sticky_nxt),
        .dac_data    (dac_arr[k]),
        .dac_en      (o_dac_en[k]),
        .precharge_n (o_precharge_n[k]),
        .result      (res_arr[k]),
        .sat         (o_sat[k])
      );
    end
  endgenerate

  assign o_dac_data = dac_arr;

  // Result readback mux; out-of-range selects read as zero.
  always_comb begin
    o_result = '0;
    for (int i = 0; i < N_CHAN; i++)
      if (i_chan_sel == CW'(i)) o_result = res_arr[i];
  end

endmodule
